// File: rtl/uart_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_packet_arbiter_if
// Purpose   : Requester byte streams and framed packetizer output of the
//             UART packet arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_packet_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]   req_valid;
    logic [8*NUM_SRC-1:0] req_data;
    logic [NUM_SRC-1:0]   req_last;
    logic [NUM_SRC-1:0]   req_ready;
    logic [7:0]           pkt_data;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 frame_done;
    logic                 truncated;

    modport master (
        input  req_valid, req_data, req_last, pkt_ready,
        output req_ready, pkt_data, pkt_valid, grant_id, busy, frame_done, truncated
    );

    modport slave (
        output req_valid, req_data, req_last, pkt_ready,
        input  req_ready, pkt_data, pkt_valid, grant_id, busy, frame_done, truncated
    );
endinterface
`default_nettype wire

// File: rtl/uart_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_arbiter
// Purpose  : Round-robin sharing of the packetizer among NUM_SRC byte streams,
//            framing each grant as SYNC / ID / payload / XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module uart_packet_arbiter #(
    parameter int         NUM_SRC   = 4,
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ID_W      = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_packet_arbiter_if.master bus
);
    localparam int               c_cnt_w   = $clog2(MAX_LEN + 1);
    localparam logic [ID_W:0]    c_num_src = (ID_W+1)'(NUM_SRC);
    localparam logic [ID_W-1:0]  c_rr_init = ID_W'(NUM_SRC - 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CSUM    = 2'd3
    } state_t;

    state_t               r_state;
    logic [7:0]           r_pkt_data;
    logic                 r_pkt_valid;
    logic [ID_W-1:0]      r_grant_id;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [7:0]           r_checksum;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_frame_done;
    logic                 r_truncated;

    state_t               w_state_nxt;
    logic                 w_slot_free;
    logic                 w_load;
    logic [7:0]           w_load_data;
    logic [ID_W-1:0]      w_grant_nxt;
    logic [ID_W-1:0]      w_rr_nxt;
    logic [7:0]           w_ck_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_fd_nxt;
    logic                 w_tr_nxt;
    logic [NUM_SRC-1:0]   w_req_ready;
    logic                 w_any;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W:0]        w_sum;
    logic [7:0]           w_src_byte;
    logic                 w_src_valid;
    logic                 w_src_last;

    assign w_slot_free = !r_pkt_valid || bus.pkt_ready;
    assign w_src_byte  = bus.req_data[{r_grant_id, 3'b000} +: 8];
    assign w_src_valid = bus.req_valid[r_grant_id];
    assign w_src_last  = bus.req_last[r_grant_id];

    // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_sum >= c_num_src) begin
                w_sum = w_sum - c_num_src;
            end
            if (bus.req_valid[w_sum[ID_W-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_grant_nxt = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        w_ck_nxt    = r_checksum;
        w_cnt_nxt   = r_count;
        w_fd_nxt    = 1'b0;
        w_tr_nxt    = 1'b0;
        w_req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_slot_free && w_any) begin
                    w_grant_nxt = w_winner;
                    w_load      = 1'b1;
                    w_load_data = SYNC_BYTE;
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_data = {{(8-ID_W){1'b0}}, r_grant_id};
                    w_ck_nxt    = {{(8-ID_W){1'b0}}, r_grant_id};
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_req_ready[r_grant_id] = w_slot_free;
                if (w_src_valid && w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_data = w_src_byte;
                    w_ck_nxt    = r_checksum ^ w_src_byte;
                    w_cnt_nxt   = r_count + 1'b1;
                    if (w_src_last) begin
                        w_state_nxt = S_CSUM;
                    end else if (r_count == c_last_cnt) begin
                        w_state_nxt = S_CSUM;
                        w_tr_nxt    = 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_checksum;
                    w_rr_nxt    = r_grant_id;
                    w_fd_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pkt_data   <= 8'h00;
            r_pkt_valid  <= 1'b0;
            r_grant_id   <= '0;
            r_rr_ptr     <= c_rr_init;
            r_checksum   <= 8'h00;
            r_count      <= '0;
            r_frame_done <= 1'b0;
            r_truncated  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_checksum   <= w_ck_nxt;
            r_count      <= w_cnt_nxt;
            r_frame_done <= w_fd_nxt;
            r_truncated  <= w_tr_nxt;
            // pkt_data is left untouched when the slot drains so a stalled byte stays stable.
            if (w_load) begin
                r_pkt_data  <= w_load_data;
                r_pkt_valid <= 1'b1;
            end else if (w_slot_free) begin
                r_pkt_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.pkt_data   = r_pkt_data;
    assign bus.pkt_valid  = r_pkt_valid;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = (r_state != S_IDLE) || r_pkt_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.truncated  = r_truncated;
endmodule
`default_nettype wire

// File: tb/tb_uart_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_packet_arbiter
// Purpose  : Directed and randomized checks of uart_packet_arbiter against a
//            frame-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_packet_arbiter;
    localparam int NUM_SRC = 4;
    localparam int MAX_LEN = 4;
    localparam int ID_W    = $clog2(NUM_SRC);

    logic clk = 1'b0;
    logic rst;
    logic rnd_ready = 1'b1;
    logic stall = 1'b0;
    bit   gaps_on = 1'b0;
    bit   rand_ready_on = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [8:0]         src_q [NUM_SRC][$];
    logic [8:0]         mdl_q [NUM_SRC][$];
    int                 mdl_rr = NUM_SRC - 1;
    int unsigned        sent_in_pkt [NUM_SRC];
    logic [NUM_SRC-1:0] hs;
    logic [8:0]         drv_head;

    logic [7:0]      got_b [$];
    logic [ID_W-1:0] got_g [$];
    int got_fd = 0;
    int got_tr = 0;

    logic [7:0] c_t1 [4]  = '{8'hA5, 8'h00, 8'h55, 8'h55};
    logic [7:0] c_t2 [5]  = '{8'hA5, 8'h02, 8'hAA, 8'h0F, 8'hA7};
    int         c_t3g [4] = '{1, 3, 1, 3};
    logic [7:0] c_t5 [12] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
                              8'hA5, 8'h00, 8'h05, 8'h06, 8'h03};

    always #5 clk = ~clk;

    uart_packet_arbiter_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

    uart_packet_arbiter #(
        .NUM_SRC(NUM_SRC), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    assign bus.pkt_ready = rnd_ready & ~stall;

    always @(posedge clk) begin
        #1;
        rnd_ready = rand_ready_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Requester model: a source may only pause inside a frame, never on a frame's first byte.
    always @(negedge clk) hs = bus.req_valid & bus.req_ready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst) begin
                src_q[i].delete();
                sent_in_pkt[i] = 0;
            end else if (hs[i] && src_q[i].size() != 0) begin
                drv_head = src_q[i].pop_front();
                if (drv_head[8]) sent_in_pkt[i] = 0;
                else             sent_in_pkt[i] = sent_in_pkt[i] + 1;
            end
            if (src_q[i].size() == 0 ||
                (gaps_on && (sent_in_pkt[i] % MAX_LEN) != 0 && $urandom_range(0, 3) == 0)) begin
                bus.req_valid[i]       = 1'b0;
                bus.req_last[i]        = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
            end else begin
                drv_head               = src_q[i][0];
                bus.req_valid[i]       = 1'b1;
                bus.req_last[i]        = drv_head[8];
                bus.req_data[8*i +: 8] = drv_head[7:0];
            end
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.pkt_valid && bus.pkt_ready) begin
                got_b.push_back(bus.pkt_data);
                got_g.push_back(bus.grant_id);
            end
            if (bus.frame_done) got_fd++;
            if (bus.truncated)  got_tr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int s, input logic [7:0] b, input bit last);
        src_q[s].push_back({last, b});
        mdl_q[s].push_back({last, b});
    endtask

    task automatic start();
        got_b.delete();
        got_g.delete();
        got_fd = 0;
        got_tr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        mdl_rr = NUM_SRC - 1;
        for (int i = 0; i < NUM_SRC; i++) mdl_q[i].delete();
    endtask

    // Reference: serve pending sources round-robin, one frame of up to MAX_LEN bytes per grant.
    task automatic run_and_check(input string tag);
        logic [7:0]      eb [$];
        logic [ID_W-1:0] eg [$];
        logic [8:0]      e;
        logic [7:0]      ck;
        int efd, etr, s, n, budget;
        bit found, lst;
        efd = 0;
        etr = 0;
        s   = 0;
        forever begin
            found = 1'b0;
            for (int j = 1; j <= NUM_SRC && !found; j++) begin
                s = (mdl_rr + j) % NUM_SRC;
                if (mdl_q[s].size() != 0) found = 1'b1;
            end
            if (!found) break;
            ck = 8'(s);
            eb.push_back(8'hA5); eg.push_back(ID_W'(s));
            eb.push_back(ck);    eg.push_back(ID_W'(s));
            n   = 0;
            lst = 1'b0;
            while (!lst && n < MAX_LEN) begin
                e = mdl_q[s].pop_front();
                eb.push_back(e[7:0]); eg.push_back(ID_W'(s));
                ck  = ck ^ e[7:0];
                lst = e[8];
                n++;
            end
            if (!lst) etr++;
            eb.push_back(ck); eg.push_back(ID_W'(s));
            efd++;
            mdl_rr = s;
        end
        budget = 0;
        while (got_b.size() < eb.size() && budget < 1500) begin
            @(posedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        #2;
        check({tag, " nbytes"}, 32'(got_b.size()), 32'(eb.size()));
        for (int k = 0; k < eb.size() && k < got_b.size(); k++) begin
            check($sformatf("%s byte%0d", tag, k), 32'(got_b[k]), 32'(eb[k]));
            check($sformatf("%s gid%0d", tag, k), 32'(got_g[k]), 32'(eg[k]));
        end
        check({tag, " frame_done"}, 32'(got_fd), 32'(efd));
        check({tag, " truncated"}, 32'(got_tr), 32'(etr));
        check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached limit 500000", $time);
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst pkt_valid",  32'(bus.pkt_valid),  32'd0);
        check("rst pkt_data",   32'(bus.pkt_data),   32'd0);
        check("rst grant_id",   32'(bus.grant_id),   32'd0);
        check("rst busy",       32'(bus.busy),       32'd0);
        check("rst frame_done", 32'(bus.frame_done), 32'd0);
        check("rst truncated",  32'(bus.truncated),  32'd0);
        check("rst req_ready",  32'(bus.req_ready),  32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        start();
        add(0, 8'h55, 1'b1);
        run_and_check("t1");
        for (int k = 0; k < 4 && k < got_b.size(); k++)
            check($sformatf("t1 const%0d", k), 32'(got_b[k]), 32'(c_t1[k]));

        start();
        add(2, 8'hAA, 1'b0);
        add(2, 8'h0F, 1'b1);
        run_and_check("t2");
        for (int k = 0; k < 5 && k < got_b.size(); k++)
            check($sformatf("t2 const%0d", k), 32'(got_b[k]), 32'(c_t2[k]));

        do_reset();
        start();
        add(1, 8'h11, 1'b1);
        add(3, 8'h33, 1'b1);
        add(1, 8'h12, 1'b1);
        add(3, 8'h34, 1'b1);
        run_and_check("t3");
        for (int k = 0; k < 4 && 4*k < got_g.size(); k++)
            check($sformatf("t3 order%0d", k), 32'(got_g[4*k]), 32'(c_t3g[k]));

        start();
        add(0, 8'h22, 1'b0);
        add(0, 8'h33, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #2;
            if (bus.pkt_valid && bus.pkt_data == 8'h33) found = 1'b1;
        end
        check("t4 stall_seen", 32'(found), 32'd1);
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t4 hold_data%0d", c),  32'(bus.pkt_data),  32'h33);
            check($sformatf("t4 hold_valid%0d", c), 32'(bus.pkt_valid), 32'd1);
            check($sformatf("t4 hold_ready%0d", c), 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #2;
        stall = 1'b0;
        run_and_check("t4");

        start();
        for (int k = 1; k <= 6; k++) add(0, 8'(k), k == 6);
        run_and_check("t5");
        for (int k = 0; k < 12 && k < got_b.size(); k++)
            check($sformatf("t5 const%0d", k), 32'(got_b[k]), 32'(c_t5[k]));

        start();
        add(1, 8'h7E, 1'b0);
        add(1, 8'h81, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #2;
            if (bus.pkt_valid && bus.pkt_data == 8'h01 && bus.grant_id == 1) found = 1'b1;
        end
        check("t6 id_seen", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("t6 pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check("t6 busy",      32'(bus.busy),      32'd0);
        check("t6 grant_id",  32'(bus.grant_id),  32'd0);
        do_reset();
        start();
        add(1, 8'h3C, 1'b1);
        run_and_check("t6");
        if (got_b.size() >= 2) begin
            check("t6 sync", 32'(got_b[0]), 32'hA5);
            check("t6 id",   32'(got_b[1]), 32'h01);
        end

        gaps_on = 1'b1;
        rand_ready_on = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bit any;
            int npk, len;
            any = 1'b0;
            start();
            for (int s = 0; s < NUM_SRC; s++) begin
                if ($urandom_range(0, 1) == 1 || (s == NUM_SRC - 1 && !any)) begin
                    any = 1'b1;
                    npk = int'($urandom_range(1, 2));
                    for (int p = 0; p < npk; p++) begin
                        len = int'($urandom_range(1, 10));
                        for (int k = 0; k < len; k++) add(s, 8'($urandom), k == len - 1);
                    end
                end
            end
            run_and_check($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_packet_arbiter.md
Name: uart_packet_arbiter

Overview:
Shares the single UART packetizer transmit path between NUM_SRC independent byte-stream requesters. Sources are served in round-robin order. The block wraps each granted stream in a frame: SYNC byte, source-ID byte, payload, then an XOR checksum. It sits in front of top_packetizer and drives its data_in/data_valid. pkt_ready is tied to the packetizer's FIFO not-full.

Parameters:
NUM_SRC, 4, number of requesters (2..16)
MAX_LEN, 16, maximum payload bytes per frame (1..255); longer streams are split
SYNC_BYTE, 8'hA5, first byte of every frame
ID_W, $clog2(NUM_SRC), width of the source index

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_SRC  per-source byte valid
req_data  input  8*NUM_SRC  per-source byte; source i uses bits [8i+7:8i]
req_last  input  NUM_SRC  per-source end-of-packet marker, qualified by req_valid
req_ready  output  NUM_SRC  per-source byte accepted this cycle
pkt_data  output  8  framed byte to packetizer data_in
pkt_valid  output  1  pkt_data valid, to packetizer data_valid
pkt_ready  input  1  downstream can accept (packetizer FIFO not full)
grant_id  output  ID_W  source owning the current frame
busy  output  1  high whenever state != IDLE or pkt_valid=1
frame_done  output  1  one-cycle pulse when the checksum byte is loaded
truncated  output  1  one-cycle pulse when a frame is closed at MAX_LEN without req_last

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pkt_valid=0; pkt_data=0; grant_id=0.
  - rr_ptr=NUM_SRC-1, so source 0 has top priority first.
  - checksum=0; count=0; frame_done=0; truncated=0.
  - Reset asserted mid-frame abandons the frame immediately. No checksum is emitted.
- Output register:
  - slot_free = !pkt_valid || pkt_ready.
  - A byte transfers on a clock edge with pkt_valid && pkt_ready.
  - While pkt_valid=1 and pkt_ready=0, pkt_data holds stable.
  - If slot_free and nothing new is loaded, pkt_valid <= 0.
- States: IDLE, HDR, PAYLOAD, CSUM. All loads require slot_free.
  - IDLE: if any req_valid, take the winner = first asserted index after rr_ptr (wrapping modulo NUM_SRC). Then grant_id<=winner, load SYNC_BYTE, go to HDR. No source byte is consumed in IDLE.
  - HDR: load ID byte = zero-extended grant_id; checksum<=ID byte; count<=0; go to PAYLOAD.
  - PAYLOAD:
    - req_ready[grant_id] = slot_free combinationally; all other req_ready bits are 0.
    - When req_valid[grant_id] && slot_free: load req_data, checksum^=byte, count++.
    - If req_last, or count==MAX_LEN-1, go to CSUM. If the second case happens without req_last, pulse truncated.
    - If req_valid is low, stay in PAYLOAD; no timeout.
  - CSUM: load checksum; rr_ptr<=grant_id; pulse frame_done; go to IDLE.
- Minimum frame on the wire is 4 bytes (SYNC, ID, one payload byte, checksum).
- Back-to-back frames have one IDLE cycle between the checksum load and the next SYNC load.
- After a truncation, the source's remaining bytes form a new frame. That frame competes in round-robin normally, with the truncated source now lowest priority.
- req_valid toggling on non-granted sources never affects the current frame.
- Checksum is 8-bit XOR; count is $clog2(MAX_LEN+1) bits and never wraps.

Test Plan:
- After reset, src0 sends 0x55 with last, pkt_ready=1 -> pkt_data sequence A5,00,55,55; frame_done pulses once; busy returns to 0.
- src2 sends AA, then 0F with last -> A5,02,AA,0F,A7; grant_id=2 throughout.
- src1 and src3 request simultaneously after reset, each sending one byte with last. Then src1 and src3 request again -> frame order src1, src3, src1, src3.
- pkt_ready held low 5 cycles during src0 payload byte 0x33 -> pkt_data=33 stable, pkt_valid=1, req_ready=0 for those cycles; the frame resumes intact.
- MAX_LEN=4; src0 sends 01..06 with last on 06 -> A5,00,01,02,03,04,04 with truncated pulse, then A5,00,05,06,03.
- rst asserted after the ID byte of a src1 frame -> pkt_valid=0 and state=IDLE immediately. The next request from src1 starts with A5,01.
